// File: rtl/ringosc_meas_pkg.sv
// Shared types and default sizing for the ring-oscillator measurement sequencer.
package ringosc_meas_pkg;

    typedef enum logic [2:0] {
        MEAS_IDLE,
        MEAS_CLEAR,
        MEAS_SETTLE,
        MEAS_GATE,
        MEAS_DRAIN
    } meas_state_t;

    localparam int MEAS_WIN_W         = 16;
    localparam int MEAS_CNT_W         = 16;
    localparam int MEAS_CLR_CYCLES    = 4;
    localparam int MEAS_SETTLE_CYCLES = 8;
    localparam int MEAS_SYNC_STAGES   = 2;

endpackage

// File: rtl/ringosc_sync_edge.sv
// Synchroniser for the asynchronous divider tap plus a rising-edge detector.
module ringosc_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic tap_async,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign sync_next[gi] = tap_async;
            end else begin : g_rest
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
            prev_reg <= 1'b0;
        end else begin
            sync_reg <= sync_next;
            prev_reg <= sync_reg[SYNC_STAGES-1];
        end
    end

    assign rise = sync_reg[SYNC_STAGES-1] & ~prev_reg;

endmodule

// File: rtl/ringosc_meas_ctrl.sv
// Measurement sequencer: clear divider, settle ring, gate tap edges, report count.
// Optional RINGOSC_MEAS_OVF_EN: saturating counter with sticky overflow flag.
module ringosc_meas_ctrl
    import ringosc_meas_pkg::*;
#(
    parameter int WIN_W         = MEAS_WIN_W,
    parameter int CNT_W         = MEAS_CNT_W,
    parameter int CLR_CYCLES    = MEAS_CLR_CYCLES,
    parameter int SETTLE_CYCLES = MEAS_SETTLE_CYCLES,
    parameter int SYNC_STAGES   = MEAS_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             tap_async,
    output logic             ring_en,
    output logic             div_rst_n,
    output logic             busy,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             overflow
);

    localparam int CYC_W = (WIN_W > 8) ? WIN_W : 8;

    meas_state_t      state_reg, state_next;
    logic [CYC_W-1:0] cyc_reg, cyc_next;
    logic [WIN_W-1:0] win_reg;
    logic             was_gate_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] result_reg;
    logic             result_valid_reg;
    logic             overflow_reg;
    logic             ring_en_reg;
    logic             div_rst_n_reg;
    logic             busy_reg;

    logic rise;
    logic start_acc;
    logic zero_load;
    logic gate_entry;
    logic load_result;
    logic count_en;

    ringosc_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk       (clk),
        .rst       (rst),
        .tap_async (tap_async),
        .rise      (rise)
    );

    assign start_acc   = (state_reg == MEAS_IDLE) && start;
    assign zero_load   = start_acc && (win_len == '0);
    assign gate_entry  = (state_reg == MEAS_SETTLE) && (cyc_reg == '0);
    assign load_result = (state_reg == MEAS_DRAIN) && (cyc_reg == '0);
    // Both the current and the previous tap sample must belong to the gate window.
    assign count_en    = (state_reg == MEAS_GATE) && was_gate_reg && rise;

    always_comb begin
        state_next = state_reg;
        cyc_next   = cyc_reg;
        case (state_reg)
            MEAS_IDLE: begin
                if (start && (win_len != '0)) begin
                    state_next = MEAS_CLEAR;
                    cyc_next   = CYC_W'(CLR_CYCLES - 1);
                end
            end
            MEAS_CLEAR: begin
                if (cyc_reg == '0) begin
                    state_next = MEAS_SETTLE;
                    cyc_next   = CYC_W'(SETTLE_CYCLES - 1);
                end else begin
                    cyc_next = cyc_reg - CYC_W'(1);
                end
            end
            MEAS_SETTLE: begin
                if (cyc_reg == '0) begin
                    state_next = MEAS_GATE;
                    cyc_next   = CYC_W'(win_reg) - CYC_W'(1);
                end else begin
                    cyc_next = cyc_reg - CYC_W'(1);
                end
            end
            MEAS_GATE: begin
                if (cyc_reg == '0) begin
                    state_next = MEAS_DRAIN;
                    cyc_next   = CYC_W'(SYNC_STAGES);
                end else begin
                    cyc_next = cyc_reg - CYC_W'(1);
                end
            end
            MEAS_DRAIN: begin
                if (cyc_reg == '0) begin
                    state_next = MEAS_IDLE;
                end else begin
                    cyc_next = cyc_reg - CYC_W'(1);
                end
            end
            default: begin
                state_next = MEAS_IDLE;
                cyc_next   = '0;
            end
        endcase
    end

    // Control outputs are decoded from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= MEAS_IDLE;
            cyc_reg       <= '0;
            win_reg       <= '0;
            was_gate_reg  <= 1'b0;
            ring_en_reg   <= 1'b0;
            div_rst_n_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cyc_reg       <= cyc_next;
            if (start_acc) begin
                win_reg <= win_len;
            end
            was_gate_reg  <= (state_reg == MEAS_GATE);
            ring_en_reg   <= (state_next == MEAS_SETTLE) || (state_next == MEAS_GATE);
            div_rst_n_reg <= (state_next == MEAS_SETTLE) || (state_next == MEAS_GATE) ||
                             (state_next == MEAS_DRAIN);
            busy_reg      <= (state_next != MEAS_IDLE);
        end
    end

`ifdef RINGOSC_MEAS_OVF_EN
    logic ovf_flag_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg      <= '0;
            ovf_flag_reg <= 1'b0;
        end else if (gate_entry) begin
            cnt_reg      <= '0;
            ovf_flag_reg <= 1'b0;
        end else if (count_en) begin
            if (&cnt_reg) begin
                ovf_flag_reg <= 1'b1;
            end else begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (gate_entry) begin
            cnt_reg <= '0;
        end else if (count_en) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end
`endif

    // A result load takes priority over a coincident acknowledge.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_reg       <= '0;
            result_valid_reg <= 1'b0;
            overflow_reg     <= 1'b0;
        end else if (load_result) begin
            result_reg       <= cnt_reg;
`ifdef RINGOSC_MEAS_OVF_EN
            overflow_reg     <= ovf_flag_reg;
`else
            overflow_reg     <= 1'b0;
`endif
            result_valid_reg <= 1'b1;
        end else if (zero_load) begin
            result_reg       <= '0;
            overflow_reg     <= 1'b0;
            result_valid_reg <= 1'b1;
        end else if (result_ack) begin
            result_valid_reg <= 1'b0;
        end
    end

    assign ring_en      = ring_en_reg;
    assign div_rst_n    = div_rst_n_reg;
    assign busy         = busy_reg;
    assign result       = result_reg;
    assign result_valid = result_valid_reg;
    assign overflow     = overflow_reg;

endmodule

// File: tb/tb_ringosc_meas_ctrl.sv
// Scoreboard bench for ringosc_meas_ctrl: a 16-bit unit and a 4-bit unit for saturation.
module tb_ringosc_meas_ctrl;

    localparam int LAT_FIXED = 4 + 8 + 2 + 2;
    localparam int HALF0     = 5;
    localparam int HALF1     = 2;
`ifdef RINGOSC_MEAS_OVF_EN
    localparam logic [15:0] OVF_RES  = 16'd15;
    localparam logic        OVF_FLAG = 1'b1;
`else
    localparam logic [15:0] OVF_RES  = 16'd0;
    localparam logic        OVF_FLAG = 1'b0;
`endif

    typedef struct {
        int unsigned due;
        logic [15:0] res;
        logic        ovf;
        logic        chk_pre;
        logic        pre_valid;
    } sb_item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start0 = 1'b0, start1 = 1'b0;
    logic [15:0] win0 = '0, win1 = '0;
    logic        tap0 = 1'b0, tap1 = 1'b0;
    logic        ack0 = 1'b0, ack1 = 1'b0;
    logic        ring_en0, ring_en1, div_rst_n0, div_rst_n1, busy0, busy1;
    logic [15:0] result0;
    logic [3:0]  result1;
    logic        valid0, valid1, ovf0, ovf1;

    int unsigned cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          ph0 = 0, ph1 = 0;
    int          ring_hi0 = 0, busy_hi0 = 0;
    sb_item_t    sb0[$];
    sb_item_t    sb1[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ringosc_meas_ctrl u_dut (
        .clk (clk), .rst (rst), .start (start0), .win_len (win0), .tap_async (tap0),
        .ring_en (ring_en0), .div_rst_n (div_rst_n0), .busy (busy0), .result (result0),
        .result_valid (valid0), .result_ack (ack0), .overflow (ovf0)
    );

    ringosc_meas_ctrl #(.CNT_W (4)) u_dut_ovf (
        .clk (clk), .rst (rst), .start (start1), .win_len (win1), .tap_async (tap1),
        .ring_en (ring_en1), .div_rst_n (div_rst_n1), .busy (busy1), .result (result1),
        .result_valid (valid1), .result_ack (ack1), .overflow (ovf1)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", tag, act, exp);
        end
    endtask

    // Divider tap model: held low while the divider is in reset, toggles every HALF enabled cycles.
    always @(negedge clk) begin
        if (div_rst_n0 !== 1'b1) begin
            ph0 = 0; tap0 = 1'b0;
        end else if (ring_en0 === 1'b1) begin
            ph0++;
            if (ph0 == HALF0) begin ph0 = 0; tap0 = ~tap0; end
        end
        if (div_rst_n1 !== 1'b1) begin
            ph1 = 0; tap1 = 1'b0;
        end else if (ring_en1 === 1'b1) begin
            ph1++;
            if (ph1 == HALF1) begin ph1 = 0; tap1 = ~tap1; end
        end
    end

    always @(negedge clk) begin
        if (ring_en0 === 1'b1) ring_hi0++;
        if (busy0 === 1'b1) busy_hi0++;
    end

    always @(negedge clk) begin
        sb_item_t it;
        if (sb0.size() > 0) begin
            if (sb0[0].chk_pre && cyc == sb0[0].due - 1)
                check_val("pre_valid0", valid0, sb0[0].pre_valid);
            if (cyc == sb0[0].due) begin
                it = sb0.pop_front();
                check_val("valid0", valid0, 1);
                check_val("result0", result0, it.res);
                check_val("overflow0", ovf0, it.ovf);
                $display("txn unit0 cyc=%0d result=%0d overflow=%0b", cyc, result0, ovf0);
            end
        end
        if (sb1.size() > 0 && cyc == sb1[0].due) begin
            it = sb1.pop_front();
            check_val("valid1", valid1, 1);
            check_val("result1", result1, it.res);
            check_val("overflow1", ovf1, it.ovf);
            $display("txn unit1 cyc=%0d result=%0d overflow=%0b", cyc, result1, ovf1);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic launch(input int unit, input int win, input logic [15:0] exp_res,
                          input logic exp_ovf, input logic chk_pre, input logic pre_valid);
        sb_item_t it;
        it.due       = (win == 0) ? cyc + 1 : cyc + LAT_FIXED + win;
        it.res       = exp_res;
        it.ovf       = exp_ovf;
        it.chk_pre   = chk_pre;
        it.pre_valid = pre_valid;
        if (unit == 0) begin
            start0 = 1'b1; win0 = 16'(win); sb0.push_back(it);
        end else begin
            start1 = 1'b1; win1 = 16'(win); sb1.push_back(it);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_drained(input int unit);
        int n = 0;
        while (((unit == 0) ? sb0.size() : sb1.size()) != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            check_val("drain_timeout", n, 0);
            sb0.delete();
            sb1.delete();
        end
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int unsigned d;
        int          n;

        // Reset held mid-IDLE
        tick(3);
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(3);
        check_val("rst_ring_en", ring_en0, 0);
        check_val("rst_div_rst_n", div_rst_n0, 0);
        check_val("rst_busy", busy0, 0);
        check_val("rst_valid", valid0, 0);
        check_val("rst_result", result0, 0);
        rst = 1'b0;
        tick(2);

        // Nominal run with a start pulse during GATE that must be ignored
        ring_hi0 = 0;
        launch(0, 100, 16'd10, 1'b0, 1'b1, 1'b0);
        tick(49);
        start0 = 1'b1; win0 = 16'd7;
        tick(1);
        start0 = 1'b0;
        wait_drained(0);
        check_val("ring_en_cycles", ring_hi0, 108);
        tick(10);
        check_val("no_second_run", busy0, 0);
        check_val("held_result", result0, 10);
        ack0 = 1'b1;
        tick(1);
        ack0 = 1'b0;
        check_val("ack_clears", valid0, 0);

        // Zero-length window
        ring_hi0 = 0;
        busy_hi0 = 0;
        launch(0, 0, 16'd0, 1'b0, 1'b0, 1'b0);
        wait_drained(0);
        tick(5);
        check_val("zero_ring_en", ring_hi0, 0);
        check_val("zero_busy", busy_hi0, 0);
        ack0 = 1'b1;
        tick(1);
        ack0 = 1'b0;

        // Pending result, then a second run whose load coincides with an acknowledge
        launch(0, 100, 16'd10, 1'b0, 1'b0, 1'b0);
        wait_drained(0);
        launch(0, 50, 16'd5, 1'b0, 1'b1, 1'b1);
        d = sb0[0].due;
        n = 0;
        while (cyc != d - 1 && n < 400) begin
            @(negedge clk);
            n++;
        end
        check_val("ack_align", (cyc == d - 1), 1);
        ack0 = 1'b1;
        tick(1);
        ack0 = 1'b0;
        wait_drained(0);

        // Reset in the middle of GATE, then a clean run
        launch(0, 100, 16'd10, 1'b0, 1'b0, 1'b0);
        tick(40);
        rst = 1'b1;
        tick(1);
        sb0.delete();
        check_val("midrst_ring_en", ring_en0, 0);
        check_val("midrst_div_rst_n", div_rst_n0, 0);
        check_val("midrst_busy", busy0, 0);
        check_val("midrst_valid", valid0, 0);
        check_val("midrst_result", result0, 0);
        check_val("midrst_overflow", ovf0, 0);
        rst = 1'b0;
        tick(2);
        launch(0, 100, 16'd10, 1'b0, 1'b0, 1'b0);
        wait_drained(0);

        // Narrow counter: 16 edges in the window
        launch(1, 64, OVF_RES, OVF_FLAG, 1'b0, 1'b0);
        wait_drained(1);
        tick(3);

        check_val("scoreboard_empty", sb0.size() + sb1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ringosc_meas_ctrl.md
# ringosc_meas_ctrl

Measurement sequencer for the 5-inverter ring oscillator and its 16-stage ripple divider. On a `start` request it clears the divider and enables the ring, then gates a window of `win_len` system-clock cycles. During the window it counts rising edges of one divider tap, synchronised into `clk`. It then stops the ring and presents the count through a valid/ack result register. The block sits between the tile's digital control and the free-running oscillator/divider macro.

## Interface
- `WIN_W`, 16, width of `win_len`
- `CNT_W`, 16, width of edge counter and `result`
- `CLR_CYCLES`, 4, cycles the divider is held in reset before each run (≥1)
- `SETTLE_CYCLES`, 8, cycles the ring runs before counting starts (≥1)
- `SYNC_STAGES`, 2, flops in the tap synchroniser (≥2)

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  reset, synchronous, active-high
- `start`  in  1  run request, single-cycle pulse
- `win_len`  in  WIN_W  gate length in `clk` cycles, sampled when `start` is accepted
- `tap_async`  in  1  divider tap, asynchronous to `clk`
- `ring_en`  out  1  ring oscillator enable (drives master enable)
- `div_rst_n`  out  1  divider reset, active-low
- `busy`  out  1  high in any state other than IDLE
- `result`  out  CNT_W  edge count of the last completed run
- `result_valid`  out  1  `result` holds an unacknowledged value
- `result_ack`  in  1  consumer acknowledge
- `overflow`  out  1  count saturated in the last run

## Operation
- States: IDLE, CLEAR, SETTLE, GATE, DRAIN.
- IDLE:
  - `ring_en`=0, `div_rst_n`=0.
  - `start`=1 latches `win_len` and moves to CLEAR. If the latched value is 0, the block instead stays in IDLE, loads `result`=0 and `overflow`=0, and sets `result_valid`.
- CLEAR: `ring_en`=0, `div_rst_n`=0 for CLR_CYCLES cycles, then SETTLE.
- SETTLE: `ring_en`=1, `div_rst_n`=1 for SETTLE_CYCLES cycles. No counting. Then GATE; the counter clears on entry to GATE.
- GATE:
  - `ring_en`=1, `div_rst_n`=1 for `win_len` cycles.
  - Counter increments on each cycle where the synchronised tap is 1 and was 0 on the previous cycle.
- DRAIN: `ring_en`=0, `div_rst_n`=1 for SYNC_STAGES+1 cycles. No counting. On exit: `result`←counter, `overflow`←flag, `result_valid`←1, state←IDLE.
- `start` is ignored while `busy`=1.
- An accepted `start` does not clear a pending `result_valid`.
- `result_ack` clears `result_valid`. If a new result is loaded in the same cycle as `result_ack`, the load wins and `result_valid` stays 1.
- The edge-detect previous-sample register updates every cycle in every state. An edge is counted only when both the current and previous samples are taken during GATE cycles.
- `rst` applies in every state:
  - state←IDLE, counter←0, synchroniser←0
  - `ring_en`=0, `div_rst_n`=0, `busy`=0
  - `result`=0, `result_valid`=0, `overflow`=0

## Timing
- All outputs are registered.
- `start` is sampled at edge T. CLEAR is visible T+1..T+CLR_CYCLES, followed by SETTLE, GATE (`win_len` cycles) and DRAIN (SYNC_STAGES+1 cycles).
- `result_valid` first high at T+CLR_CYCLES+SETTLE_CYCLES+`win_len`+SYNC_STAGES+2. With defaults and `win_len`=100 this is T+116.
- `win_len`=0: `result_valid` high at T+1, `busy` never asserts.
- Tap edges closer than 2 `clk` cycles apart are undercounted. This is a documented limitation; select a divider tap slow enough to avoid it.

## Configuration
- `RINGOSC_MEAS_OVF_EN` defined:
  - Counter saturates at 2^CNT_W−1.
  - A sticky flag sets on any increment attempted at saturation and is reported on `overflow`.
- Undefined: counter wraps modulo 2^CNT_W and `overflow` is tied to 0.

## Structure
- Package `ringosc_meas_pkg` holds the state enum (`MEAS_IDLE`, `MEAS_CLEAR`, `MEAS_SETTLE`, `MEAS_GATE`, `MEAS_DRAIN`) and the default width and length constants.
- One sub-module, `ringosc_sync_edge`, contains the SYNC_STAGES flop chain plus a registered previous sample. It outputs a single-cycle `rise` pulse and resets synchronously to 0.
- FSM, cycle counter, edge counter and result register live in the top module.

## Test plan
- **Reset:** assert `rst` for 3 cycles mid-IDLE → `ring_en`=0, `div_rst_n`=0, `busy`=0, `result_valid`=0, `result`=0.
- **Nominal run:** tap model toggles with period 10 `clk` while `ring_en`=1; `start` with `win_len`=100 → `result`=10, `result_valid` rises exactly 116 cycles after `start`; `ring_en` high for exactly 108 cycles.
- **Zero window:** `win_len`=0 → `result_valid` at T+1, `result`=0, `ring_en` never 1.
- **Handshake:** `start` pulsed during GATE is ignored (single run). `result_ack` clears `result_valid`. A second run completing in the same cycle as `result_ack` leaves `result_valid`=1 with the new count.
- **Overflow** (`CNT_W`=4, tap period 4, `win_len`=64, 16 edges):
  - Macro defined → `result`=15, `overflow`=1.
  - Macro undefined → `result`=0, `overflow`=0.
- **Mid-run reset:** assert `rst` during GATE → all outputs at reset values at the next edge. A following `start` with `win_len`=100 again yields `result`=10.
